// File: rtl/cache_arbiter.sv
// Arbitrates the shared cacheline-adaptor port between the I-cache and D-cache.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the D-cache wins ties.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  state_t state, state_next;
  logic   i_req, d_req, grant_i, grant_d, serving;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0: I-cache granted last, 1: D-cache granted last
`endif

  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  // Next-state and grant decision
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          grant_i = last_grant;
          grant_d = ~last_grant;
`else
          grant_d = 1'b1;
`endif
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I, SERVE_D: if (mem_resp) state_next = RECOVER;
      RECOVER:          state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  // State and latched request; the op is held until the adaptor responds
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 32'd0;
      mem_wdata   <= 256'd0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
        mem_address <= i_pmem_address;
      end else if (grant_d) begin
        mem_read    <= ~d_pmem_write;
        mem_write   <= d_pmem_write;
        mem_address <= d_pmem_address;
        mem_wdata   <= d_pmem_wdata;
      end else if (serving && mem_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)                     last_grant <= 1'b0;
    else if (grant_i || grant_d) last_grant <= grant_d;
  end
`endif

  // A D-cache read and write-back at once is a controller bug; the write is issued
  always_ff @(posedge clk) begin
    if (!rst && grant_d)
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, write issued");
  end

  assign i_pmem_resp  = (state == SERVE_I) && mem_resp;
  assign d_pmem_resp  = (state == SERVE_D) && mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized
// transaction-level model of grant order, latching and response steering.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_err = 0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Tie rule: 1 = I-cache, 2 = D-cache; last_d means the D-cache won the previous grant
  function automatic int pick(bit i, bit d, bit last_d);
    if (i && d) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      return last_d ? 1 : 2;
`else
      return 2;
`endif
    end
    return i ? 1 : 2;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = 32'd0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = 32'd0; d_pmem_wdata = 256'd0;
    mem_rdata = 256'd0; mem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    n_cmp++;
    if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    n_cmp++;
    if (mem_address !== 32'd0) begin n_err++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    n_cmp++;
    if (mem_wdata !== 256'd0) begin n_err++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL reset_resp got i=%b d=%b exp 0 0", i_pmem_resp, d_pmem_resp);
    end
    n_cmp++;
  endtask

  task automatic test_i_read();
    logic [255:0] pat_a;
    pat_a = {8{32'hA5A5_5A5A}};
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    tick();
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL iread_op got r=%b w=%b exp r=1 w=0", mem_read, mem_write);
    end
    n_cmp++;
    if (mem_address !== 32'h0000_1000) begin n_err++; $display("FAIL iread_addr got=%h exp=00001000", mem_address); end
    n_cmp++;
    repeat (3) tick();
    if (mem_read !== 1'b1) begin n_err++; $display("FAIL iread_hold got=%b exp=1", mem_read); end
    n_cmp++;
    mem_resp = 1'b1; mem_rdata = pat_a;
    #1;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL iread_resp got i=%b d=%b exp i=1 d=0", i_pmem_resp, d_pmem_resp);
    end
    n_cmp++;
    if (i_pmem_rdata !== pat_a) begin n_err++; $display("FAIL iread_rdata got=%h exp=%h", i_pmem_rdata, pat_a); end
    n_cmp++;
    tick();
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    #1;
    if (mem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL iread_recover got r=%b resp=%b exp 0 0", mem_read, i_pmem_resp);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_d_write();
    logic [255:0] pat_b;
    pat_b = {8{32'hDEAD_BEEF}};
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = pat_b;
    tick();
    d_pmem_wdata = 256'd0;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL dwr_op got r=%b w=%b exp r=0 w=1", mem_read, mem_write);
    end
    n_cmp++;
    if (mem_address !== 32'h8000_0040) begin n_err++; $display("FAIL dwr_addr got=%h exp=80000040", mem_address); end
    n_cmp++;
    repeat (2) tick();
    if (mem_wdata !== pat_b) begin n_err++; $display("FAIL dwr_wdata_held got=%h exp=%h", mem_wdata, pat_b); end
    n_cmp++;
    mem_resp = 1'b1;
    #1;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL dwr_resp got d=%b i=%b exp d=1 i=0", d_pmem_resp, i_pmem_resp);
    end
    n_cmp++;
    tick();
    mem_resp = 1'b0; d_pmem_write = 1'b0;
    if (mem_write !== 1'b0) begin n_err++; $display("FAIL dwr_recover got=%b exp=0", mem_write); end
    n_cmp++;
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    tick();
    if (mem_address !== 32'h0000_3000 || mem_read !== 1'b1) begin
      n_err++; $display("FAIL tie_first got addr=%h r=%b exp addr=00003000 r=1", mem_address, mem_read);
    end
    n_cmp++;
    tick();
    mem_resp = 1'b1;
    #1;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL tie_resp got d=%b i=%b exp d=1 i=0", d_pmem_resp, i_pmem_resp);
    end
    n_cmp++;
    tick();
    mem_resp = 1'b0; d_pmem_read = 1'b0;
    tick();
    if (mem_read !== 1'b0) begin n_err++; $display("FAIL tie_gap got=%b exp=0 at resp+2", mem_read); end
    n_cmp++;
    tick();
    if (mem_read !== 1'b1 || mem_address !== 32'h0000_2000) begin
      n_err++; $display("FAIL tie_second got r=%b addr=%h exp r=1 addr=00002000", mem_read, mem_address);
    end
    n_cmp++;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; i_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit last_d;
    int exp_owner, w;
    logic [31:0] exp_addr;
    do_reset();
    last_d = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      exp_owner = pick(1'b1, 1'b1, last_d);
      last_d = (exp_owner == 2);
      exp_addr = (exp_owner == 1) ? 32'h0000_0100 : 32'h0000_0200;
      w = 0;
      while (!(mem_read || mem_write) && w < 10) begin tick(); w++; end
      if (w >= 10) begin n_err++; $display("FAIL b2b_timeout txn=%0d no request within 10 cycles", k); end
      n_cmp++;
      if (mem_address !== exp_addr) begin
        n_err++; $display("FAIL b2b_owner txn=%0d got addr=%h exp addr=%h", k, mem_address, exp_addr);
      end
      n_cmp++;
      repeat (2) tick();
      mem_resp = 1'b1;
      #1;
      if (i_pmem_resp !== (exp_owner == 1) || d_pmem_resp !== (exp_owner == 2)) begin
        n_err++; $display("FAIL b2b_resp txn=%0d got i=%b d=%b exp owner=%0d", k, i_pmem_resp, d_pmem_resp, exp_owner);
      end
      n_cmp++;
      tick();
      mem_resp = 1'b0;
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0300;
    tick();
    if (mem_read !== 1'b1) begin n_err++; $display("FAIL rstmid_grant got=%b exp=1", mem_read); end
    n_cmp++;
    tick();
    rst = 1'b1; d_pmem_read = 1'b0;
    tick();
    rst = 1'b0; mem_resp = 1'b1;
    #1;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 32'd0 || mem_wdata !== 256'd0) begin
      n_err++; $display("FAIL rstmid_outputs got r=%b w=%b addr=%h exp all zero", mem_read, mem_write, mem_address);
    end
    n_cmp++;
    if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL rstmid_late_resp got d=%b i=%b exp 0 0", d_pmem_resp, i_pmem_resp);
    end
    n_cmp++;
    tick();
    mem_resp = 1'b0;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL rstmid_idle got r=%b w=%b exp 0 0", mem_read, mem_write);
    end
    n_cmp++;
  endtask

  task automatic test_rw_both();
    logic [255:0] pat_c;
    pat_c = {8{32'h1234_5678}};
    do_reset();
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_0400; d_pmem_wdata = pat_c;
    tick();
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== pat_c) begin
      n_err++; $display("FAIL rw_both got r=%b w=%b wdata=%h exp r=0 w=1 wdata=%h", mem_read, mem_write, mem_wdata, pat_c);
    end
    n_cmp++;
    mem_resp = 1'b1;
    #1;
    if (d_pmem_resp !== 1'b1) begin n_err++; $display("FAIL rw_both_resp got=%b exp=1", d_pmem_resp); end
    n_cmp++;
    tick();
    mem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick();
  endtask

  // Transaction-level model: each requester holds one pending line request; the
  // port may decide two cycles after a completion and the winner follows the tie rule.
  task automatic test_random();
    bit          i_pend, d_pend, d_wr, last_d;
    logic [31:0] i_addr, d_addr;
    logic [255:0] d_data, rd;
    int owner, lat, free_at, i_ok_at, d_ok_at, done;
    do_reset();
    i_pend = 0; d_pend = 0; last_d = 0; owner = 0; lat = 0;
    free_at = 0; i_ok_at = 0; d_ok_at = 0; done = 0;
    i_addr = 0; d_addr = 0; d_data = 0; d_wr = 0;
    for (int c = 0; c < 4000 && done < 40; c++) begin
      if (!i_pend && c >= i_ok_at && ($urandom_range(0, 2) == 0)) begin
        i_pend = 1; i_addr = $urandom() & 32'hFFFF_FFE0;
      end
      if (!d_pend && c >= d_ok_at && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1; d_addr = $urandom() & 32'hFFFF_FFE0;
        d_wr = $urandom_range(0, 1) == 1; d_data = rand256();
      end
      i_pmem_read = i_pend; i_pmem_address = i_addr;
      d_pmem_read = d_pend && !d_wr; d_pmem_write = d_pend && d_wr;
      d_pmem_address = d_addr; d_pmem_wdata = d_pend ? d_data : rand256();
      rd = rand256();
      mem_rdata = rd;
      mem_resp = (owner != 0) ? (lat == 0) : ($urandom_range(0, 3) == 0);
      #1;
      if (owner == 1) begin
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== i_addr) begin
          n_err++; $display("FAIL rnd_i_req cyc=%0d got r=%b w=%b addr=%h exp r=1 w=0 addr=%h", c, mem_read, mem_write, mem_address, i_addr);
        end
        n_cmp++;
      end else if (owner == 2) begin
        if (mem_read !== !d_wr || mem_write !== d_wr || mem_address !== d_addr || (d_wr && mem_wdata !== d_data)) begin
          n_err++; $display("FAIL rnd_d_req cyc=%0d got r=%b w=%b addr=%h exp w=%b addr=%h", c, mem_read, mem_write, mem_address, d_wr, d_addr);
        end
        n_cmp++;
      end else begin
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
          n_err++; $display("FAIL rnd_idle_req cyc=%0d got r=%b w=%b exp 0 0", c, mem_read, mem_write);
        end
        n_cmp++;
      end
      if (i_pmem_resp !== (owner == 1 && mem_resp) || d_pmem_resp !== (owner == 2 && mem_resp)) begin
        n_err++; $display("FAIL rnd_resp cyc=%0d got i=%b d=%b exp owner=%0d mem_resp=%b", c, i_pmem_resp, d_pmem_resp, owner, mem_resp);
      end
      n_cmp++;
      if (owner != 0 && mem_resp) begin
        if ((owner == 1 ? i_pmem_rdata : d_pmem_rdata) !== rd) begin
          n_err++; $display("FAIL rnd_rdata cyc=%0d owner=%0d", c, owner);
        end
        n_cmp++;
      end
      if (owner != 0 && mem_resp) begin
        if (owner == 1) begin i_pend = 0; i_ok_at = c + 1; end
        else begin d_pend = 0; d_ok_at = c + 1; end
        owner = 0; free_at = c + 2; done++;
      end else if (owner != 0) begin
        lat--;
      end else if (c >= free_at && (i_pend || d_pend)) begin
        owner = pick(i_pend, d_pend, last_d);
        last_d = (owner == 2);
        lat = $urandom_range(0, 4);
      end
      tick();
    end
    if (done < 40) begin n_err++; $display("FAIL rnd_progress got=%0d completions exp=40", done); end
    n_cmp++;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; mem_resp = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single cacheline adaptor / physical-memory port between the instruction cache (line reads only) and the data cache (line reads and write-backs). Sits between the two cache controllers' `pmem_*` interfaces and the cacheline adaptor. Grants one 256-bit line transaction at a time and latches the winner's request until memory responds. Steers the response and read data back to the owner only.

## Interface
Parameters:
- none (line width fixed at 256, address width 32)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_pmem_read`  in  1  I-cache line read request
- `i_pmem_address`  in  32  I-cache line address
- `i_pmem_rdata`  out  256  line data to I-cache
- `i_pmem_resp`  out  1  I-cache transaction complete
- `d_pmem_read`  in  1  D-cache line read request
- `d_pmem_write`  in  1  D-cache write-back request
- `d_pmem_address`  in  32  D-cache line address
- `d_pmem_wdata`  in  256  D-cache write-back data
- `d_pmem_rdata`  out  256  line data to D-cache
- `d_pmem_resp`  out  1  D-cache transaction complete
- `mem_read`  out  1  read request to cacheline adaptor
- `mem_write`  out  1  write request to cacheline adaptor
- `mem_address`  out  32  latched address
- `mem_wdata`  out  256  latched write data
- `mem_rdata`  in  256  line data from adaptor
- `mem_resp`  in  1  adaptor transaction complete

## Operation
- States:
  - `IDLE`: no memory request.
  - `SERVE_I`: I-cache owns the port.
  - `SERVE_D`: D-cache owns the port.
  - `RECOVER`: one-cycle gap after every completion.
- In `IDLE`, requests are sampled:
  - `i_req = i_pmem_read`; `d_req = d_pmem_read | d_pmem_write`.
  - Exactly one requesting: grant it.
  - Both requesting: tie resolved per Configuration.
  - On grant, capture into registers: `mem_address`; `mem_wdata` (D only); op type. If `d_pmem_read` and `d_pmem_write` are both high, the write wins and a simulation-only assertion fires.
- In `SERVE_x`:
  - `mem_read`/`mem_write` are driven from the latched op and held until `mem_resp`, even if the requester drops its request.
  - On `mem_resp`, the owner's `*_pmem_resp` = 1 in the same cycle, and its `*_pmem_rdata = mem_rdata` (combinational pass-through). The non-owner sees resp 0.
  - Next state is `RECOVER`.
- `RECOVER`: all mem requests are 0; next state is `IDLE`. This guarantees the adaptor sees the request deassert between transactions and gives the requester one cycle to drop its request after resp.
- `*_pmem_rdata` when not responding: `mem_rdata` (don't-care to consumer).
- Reset in any state: state goes to `IDLE` and the latched op is cleared. Any in-flight transaction is abandoned; the adaptor is reset on the same `rst`.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_wdata`=0, `i_pmem_resp`=0, `d_pmem_resp`=0, state=`IDLE`, `last_grant`=I.
- Request seen in `IDLE` at cycle N: `mem_read`/`mem_write` asserted at N+1.
- `mem_resp` at cycle M: owner resp at M; mem requests low at M+1 (`RECOVER`).
- Earliest next grant decision is at M+2 (`IDLE`); the next mem request asserts at M+3.
- Minimum arbiter overhead per transaction: 3 cycles beyond adaptor latency.
- `mem_resp` in `IDLE` or `RECOVER` is ignored; no resp is forwarded.
- Requester contract: hold the request until its resp; deassert or re-request at resp+1 or later.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit `last_grant` register updates at each grant.
  - On a tie, the requester not in `last_grant` wins.
  - Reset `last_grant`=I, so the first tie goes to D.
- Undefined:
  - Fixed priority; D-cache always wins ties.
  - `last_grant` is not implemented.
  - I-cache can starve under continuous D traffic; this is accepted for the simple config.

## Test plan
- I read only: `i_pmem_read`=1, addr 0x0000_1000; adaptor resp after 4 cycles with `rdata`=pattern A -> `mem_read`=1 one cycle after request, `mem_address`=0x1000, `i_pmem_resp` pulses with A, `d_pmem_resp` stays 0.
- D write-back: `d_pmem_write`=1, addr 0x8000_0040, wdata B; requester drops wdata to 0 mid-serve -> `mem_write`=1, `mem_wdata` stays B until resp, then `mem_write`=0 for `RECOVER`.
- Tie: both request in the same `IDLE` cycle -> D served first (both configs after reset); I granted at resp+2, with `mem_read` at resp+3.
- Back-to-back ties, 4 transactions with both requesting continuously -> RR build: D,I,D,I; fixed build: D,D,D,D with I starved.
- Reset mid-transaction: `rst` in `SERVE_D` before `mem_resp` -> next cycle all outputs 0, state `IDLE`; a late `mem_resp` is not forwarded.
- D read+write both high -> write issued (`mem_write`=1, `mem_read`=0), assertion reported.
